// File: rtl/dmg_irq_ctrl_if.sv
// CPU-side bus of the DMG interrupt controller: register access strobes,
// readback, the dispatch request/acknowledge pair and the HALT wake-up.
// The CPU control unit takes the master side and the controller takes the slave side.
interface dmg_irq_ctrl_if;
  logic [7:0] wdata;
  logic       wr_if;
  logic       wr_ie;
  logic       ime_set;
  logic       ime_clr;
  logic [7:0] if_q;
  logic [7:0] ie_q;
  logic       irq;
  logic [7:0] vec;
  logic       ack;
  logic       halted;
  logic       wake;

  modport master (
    output wdata, wr_if, wr_ie, ime_set, ime_clr, ack, halted,
    input  if_q, ie_q, irq, vec, wake
  );

  modport slave (
    input  wdata, wr_if, wr_ie, ime_set, ime_clr, ack, halted,
    output if_q, ie_q, irq, vec, wake
  );
endinterface

// File: rtl/dmg_irq_ctrl.sv
// DMG interrupt controller: IF/IE/IME registers, fixed-priority arbitration
// (bit 0 highest), IDLE/REQ dispatch handshake and the HALT wake-up.
// Optional feature macro: DMG_IRQ_EDGE_DETECT_EN.
//   defined   - IF bits are set on a rising edge of src.
//   undefined - IF bits are set on every cycle src is high (level capture).
module dmg_irq_ctrl #(
  parameter int         NSRC     = 5,
  parameter logic [7:0] VEC_BASE = 8'h40
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [NSRC-1:0]  src,
  dmg_irq_ctrl_if.slave    bus
);

  localparam int GW = $clog2(NSRC);

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t            state_q, state_d;
  logic [NSRC-1:0]   flag_q, flag_d;
  logic [7:0]        enable_q, enable_d;
  logic              ime_q, ime_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [7:0]        vec_q, vec_d;

  logic [NSRC-1:0]   hw_set;
  logic [NSRC-1:0]   pending;
  logic [GW-1:0]     pick_idx;
  logic              pick_vld;
  logic              accept;

  // HALT status is informational; the CPU leaves HALT on wake alone.
  logic unused_halted;
  assign unused_halted = bus.halted;

`ifdef DMG_IRQ_EDGE_DETECT_EN
  logic [NSRC-1:0]   src_dly_q;

  // Delay the raw request lines one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!nreset) src_dly_q <= '0;
    else         src_dly_q <= src;
  end

  assign hw_set = src & ~src_dly_q;
`else
  assign hw_set = src;
`endif

  assign pending = flag_q & enable_q[NSRC-1:0];

  // Fixed-priority pick: lowest index among pending enabled sources.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_idx = GW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  // Dispatch FSM: grant in IDLE, hold grant in REQ until ack or cancel.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    gnt_d   = gnt_q;
    vec_d   = vec_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ime_q && pick_vld) begin
          state_d = ST_REQ;
          gnt_d   = pick_idx;
          vec_d   = VEC_BASE + 8'(pick_idx) * 8'd8;
        end
      end
      ST_REQ: begin
        // Acceptance takes precedence over a simultaneous cancel condition.
        if (bus.ack) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end else if (!ime_q || !pending[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IF next state per bit: hardware set, then dispatch clear, then CPU write.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NSRC; i++) begin
      if (hw_set[i])                          flag_d[i] = 1'b1;
      else if (accept && (gnt_q == GW'(i)))   flag_d[i] = 1'b0;
      else if (bus.wr_if)                     flag_d[i] = bus.wdata[i];
    end
  end

  // IE load and IME control: DI beats EI, dispatch acceptance clears IME.
  always_comb begin
    enable_d = bus.wr_ie ? bus.wdata : enable_q;
    ime_d    = ime_q;
    if (bus.ime_clr)      ime_d = 1'b0;
    else if (accept)      ime_d = 1'b0;
    else if (bus.ime_set) ime_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nreset) begin
      state_q  <= ST_IDLE;
      flag_q   <= '0;
      enable_q <= '0;
      ime_q    <= 1'b0;
      gnt_q    <= '0;
      vec_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      enable_q <= enable_d;
      ime_q    <= ime_d;
      gnt_q    <= gnt_d;
      vec_q    <= vec_d;
    end
  end

  assign bus.if_q = {{(8 - NSRC){1'b1}}, flag_q};
  assign bus.ie_q = enable_q;
  assign bus.irq  = (state_q == ST_REQ);
  assign bus.vec  = vec_q;
  assign bus.wake = |pending;

endmodule

// File: tb/tb_dmg_irq_ctrl.sv
// Self-checking bench for dmg_irq_ctrl. Expected dispatch vectors are pushed
// to a scoreboard when stimulus is applied and popped when irq rises.
module tb_dmg_irq_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [4:0] src;

  dmg_irq_ctrl_if bus ();

  dmg_irq_ctrl #(
    .NSRC     (5),
    .VEC_BASE (8'h40)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .src    (src),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for irq, then compare vec against the scoreboard head.
  task automatic wait_irq(input string tag, input int budget);
    logic [7:0] exp_vec;
    int c;
    c = 0;
    while (!bus.irq && c < budget) begin
      step();
      c++;
    end
    exp_vec = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    check({tag, "_irq"}, bus.irq, 1'b1);
    check({tag, "_vec"}, bus.vec, exp_vec);
  endtask

  task automatic ack_dispatch();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    nreset      = 1'b0;
    src         = 5'h1F;
    bus.wdata   = 8'h00;
    bus.wr_if   = 1'b0;
    bus.wr_ie   = 1'b0;
    bus.ime_set = 1'b0;
    bus.ime_clr = 1'b0;
    bus.ack     = 1'b0;
    bus.halted  = 1'b0;

    // Reset with all sources asserted.
    step();
    check("rst_if",   bus.if_q, 8'hE0);
    check("rst_ie",   bus.ie_q, 8'h00);
    check("rst_irq",  bus.irq,  1'b0);
    check("rst_vec",  bus.vec,  8'h00);
    check("rst_wake", bus.wake, 1'b0);
    nreset = 1'b1;
    src    = 5'h00;
    step();
    check("idle_if", bus.if_q, 8'hE0);

    // Priority: Timer and Joypad together, Timer wins.
    bus.wr_ie = 1'b1; bus.wdata = 8'h1F; bus.ime_set = 1'b1;
    step();
    bus.wr_ie = 1'b0; bus.ime_set = 1'b0;
    check("ie_load", bus.ie_q, 8'h1F);
    src = 5'b10100;
    sb_q.push_back(8'h50);
    step();
    src = 5'h00;
    check("prio_if_k",   bus.if_q, 8'hF4);
    check("prio_irq_k",  bus.irq,  1'b0);
    check("prio_wake_k", bus.wake, 1'b1);
    step();
    wait_irq("prio_k1", 0);
    ack_dispatch();
    check("prio_ack_irq", bus.irq,  1'b0);
    check("prio_ack_if",  bus.if_q, 8'hF0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.irq) seen = 1'b1;
    end
    check("prio_ime_off", seen, 1'b0);
    bus.ime_set = 1'b1;
    sb_q.push_back(8'h60);
    step();
    bus.ime_set = 1'b0;
    wait_irq("prio_second", 4);
    ack_dispatch();
    check("prio_done_if", bus.if_q, 8'hE0);

    // Collision: VBlank edge with a CPU write of IF=0.
    src = 5'h01; bus.wr_if = 1'b1; bus.wdata = 8'h00;
    step();
    src = 5'h00; bus.wr_if = 1'b0;
    check("coll_if", bus.if_q, 8'hE1);
    bus.wr_if = 1'b1; bus.wdata = 8'h00;
    step();
    bus.wr_if = 1'b0;
    check("coll_clear", bus.if_q, 8'hE0);

    // Cancel: IF cleared by the CPU while in REQ; late ack is ignored.
    bus.ime_set = 1'b1; bus.wr_if = 1'b1; bus.wdata = 8'h02;
    sb_q.push_back(8'h48);
    step();
    bus.ime_set = 1'b0; bus.wr_if = 1'b0;
    wait_irq("cancel_req", 4);
    bus.wr_if = 1'b1; bus.wdata = 8'h00;
    step();
    bus.wr_if = 1'b0;
    step();
    check("cancel_irq", bus.irq, 1'b0);
    ack_dispatch();
    check("cancel_ack_irq", bus.irq,  1'b0);
    check("cancel_ack_if",  bus.if_q, 8'hE0);
    // IME survived the ignored ack, so a new request dispatches.
    bus.wr_if = 1'b1; bus.wdata = 8'h01;
    sb_q.push_back(8'h40);
    step();
    bus.wr_if = 1'b0;
    wait_irq("cancel_ime_kept", 4);
    ack_dispatch();

    // HALT wake with IME=0.
    bus.wr_ie = 1'b1; bus.wdata = 8'h08;
    step();
    bus.wr_ie = 1'b0;
    bus.halted = 1'b1;
    src = 5'h08;
    step();
    src = 5'h00;
    check("halt_wake", bus.wake, 1'b1);
    check("halt_irq0", bus.irq,  1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.irq) seen = 1'b1;
    end
    check("halt_no_irq", seen, 1'b0);
    bus.wr_if = 1'b1; bus.wdata = 8'h00;
    step();
    bus.wr_if = 1'b0;
    bus.halted = 1'b0;
    check("halt_wake_clr", bus.wake, 1'b0);

    // Held STAT source: level capture re-dispatches, edge capture does not.
    bus.wr_ie = 1'b1; bus.wdata = 8'h02; bus.ime_set = 1'b1;
    step();
    bus.wr_ie = 1'b0; bus.ime_set = 1'b0;
    src = 5'h02;
    sb_q.push_back(8'h48);
    wait_irq("held_first", 5);
    ack_dispatch();
`ifdef DMG_IRQ_EDGE_DETECT_EN
    check("held_if_after_ack", bus.if_q, 8'hE0);
`else
    check("held_if_after_ack", bus.if_q, 8'hE2);
`endif
    bus.ime_set = 1'b1;
    step();
    bus.ime_set = 1'b0;
`ifdef DMG_IRQ_EDGE_DETECT_EN
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.irq) seen = 1'b1;
    end
    check("held_no_second", seen, 1'b0);
    src = 5'h00;
    bus.ime_clr = 1'b1;
    step();
    bus.ime_clr = 1'b0;
`else
    sb_q.push_back(8'h48);
    wait_irq("held_second", 4);
    src = 5'h00;
    ack_dispatch();
`endif
    check("held_done_if", bus.if_q, 8'hE0);

    // Reset taken mid-dispatch.
    bus.ime_set = 1'b1; bus.wr_if = 1'b1; bus.wdata = 8'h02;
    sb_q.push_back(8'h48);
    step();
    bus.ime_set = 1'b0; bus.wr_if = 1'b0;
    wait_irq("mid_req", 4);
    nreset = 1'b0;
    step();
    check("mid_rst_irq", bus.irq,  1'b0);
    check("mid_rst_vec", bus.vec,  8'h00);
    check("mid_rst_if",  bus.if_q, 8'hE0);
    check("mid_rst_ie",  bus.ie_q, 8'h00);
    nreset = 1'b1;
    step();
    check("mid_rst_wake", bus.wake, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
